psum_accum_buf: RTL and testbench

Output-side accumulation buffer placed directly downstream of `top_neurex`. Captures the `SYS_COL` partial-sum lanes the systolic array emits per cycle (`out_wr_data`) and accumulates them into an on-chip buffer across `num_pass` reduction passes, where a pass is one `SYS_ROW`-deep slice of `num_common`. Once accumulation completes, it drains the finished rows to the writeback path over a valid/ready stream. The psum input has no backpressure, because the array cannot stall.

---
 rtl/neurex_pkg.sv | 17 +
 rtl/psum_accum_lane.sv | 37 +++
 rtl/psum_accum_buf.sv | 147 ++++++++++++++
 tb/tb_psum_accum_buf.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/neurex_pkg.sv
// Shared types and sizing for the NeuReX output-side datapath.
package neurex_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int PSUM_WIDTH = 2 * DATA_WIDTH;
    localparam int SYS_COL    = 4;
    localparam int ACCUM_SIZE = 32;

    typedef logic [PSUM_WIDTH-1:0] psum_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN
    } accum_state_e;

endpackage

// File: rtl/psum_accum_lane.sv
// One psum lane: a flop-array row buffer with an overwrite/add write port
// and a registered read port.
module psum_accum_lane #(
    parameter int  PSUM_WIDTH = 32,
    parameter int  ACCUM_SIZE = 32,
    localparam int AW         = $clog2(ACCUM_SIZE)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wr_en,
    input  logic                  wr_overwrite,
    input  logic [AW-1:0]         wr_addr,
    input  logic [PSUM_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [PSUM_WIDTH-1:0] rd_data
);

    logic [PSUM_WIDTH-1:0] mem [ACCUM_SIZE];

    // Single-cycle read-modify-write, so same-row beats on consecutive cycles
    // always see the previous update.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_overwrite ? wr_data : mem[wr_addr] + wr_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/psum_accum_buf.sv
// Accumulates systolic-array psum rows over several reduction passes, then
// drains the finished rows over a valid/ready stream.
module psum_accum_buf #(
    parameter int  SYS_COL    = neurex_pkg::SYS_COL,
    parameter int  DATA_WIDTH = neurex_pkg::DATA_WIDTH,
    parameter int  PSUM_WIDTH = 2 * DATA_WIDTH,
    parameter int  ACCUM_SIZE = neurex_pkg::ACCUM_SIZE,
    localparam int AW         = $clog2(ACCUM_SIZE)
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                start,
    input  logic [DATA_WIDTH-1:0]               num_rows,
    input  logic [DATA_WIDTH-1:0]               num_pass,
    input  logic                                psum_valid,
    input  logic [AW-1:0]                       psum_addr,
    input  logic [0:SYS_COL-1][PSUM_WIDTH-1:0]  psum_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [AW-1:0]                       out_addr,
    output logic [0:SYS_COL-1][PSUM_WIDTH-1:0]  out_data,
    output logic                                busy,
    output logic                                done,
    output logic                                err
);

    import neurex_pkg::*;

    accum_state_e          state;
    accum_state_e          state_next;
    logic [AW:0]           num_rows_q;
    logic [DATA_WIDTH-1:0] num_pass_q;
    logic [DATA_WIDTH-1:0] pass_cnt;
    logic [DATA_WIDTH-1:0] pass_next;
    logic [AW-1:0]         last_addr;
    logic [AW-1:0]         drain_ptr;
    logic                  cfg_ok;
    logic                  start_ok;
    logic                  beat_in_range;
    logic                  beat_ok;
    logic                  beat_last;
    logic                  pass_done;
    logic                  out_fire;
    logic                  out_last;
    logic                  drain_load;
    logic                  err_set;

    assign cfg_ok        = (num_rows != '0) && (num_rows <= DATA_WIDTH'(ACCUM_SIZE))
                           && (num_pass != '0);
    assign start_ok      = (state == IDLE) && start && cfg_ok;
    assign beat_in_range = ({1'b0, psum_addr} < num_rows_q);
    assign beat_ok       = (state == ACCUM) && psum_valid && beat_in_range;
    assign last_addr     = AW'(num_rows_q - (AW + 1)'(1));
    assign beat_last     = (psum_addr == last_addr);
    assign pass_next     = pass_cnt + DATA_WIDTH'(1);
    assign pass_done     = beat_ok && beat_last && (pass_next == num_pass_q);
    assign out_fire      = out_valid && out_ready;
    assign out_last      = (out_addr == last_addr);
    // Fetch the next row when the output register is empty or being emptied.
    assign drain_load    = (state == DRAIN) && (!out_valid || (out_ready && !out_last));
    assign err_set       = (start && (state == IDLE) && !cfg_ok)
                           || (psum_valid && ((state != ACCUM) || !beat_in_range));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start_ok) state_next = ACCUM;
            ACCUM:   if (pass_done) state_next = DRAIN;
            DRAIN:   if (out_fire && out_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            num_rows_q <= '0;
            num_pass_q <= '0;
            pass_cnt   <= '0;
            drain_ptr  <= '0;
        end else begin
            if (start_ok) begin
                num_rows_q <= num_rows[AW:0];
                num_pass_q <= num_pass;
                pass_cnt   <= '0;
            end else if (beat_ok && beat_last) begin
                pass_cnt <= pass_next;
            end
            if (pass_done) begin
                drain_ptr <= '0;
            end else if (drain_load) begin
                drain_ptr <= drain_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_addr  <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (drain_load) begin
                out_valid <= 1'b1;
                out_addr  <= drain_ptr;
            end else if (out_fire && out_last) begin
                out_valid <= 1'b0;
            end
            done <= (state == DRAIN) && out_fire && out_last;
            if (err_set) begin
                err <= 1'b1;
            end else if (start_ok) begin
                err <= 1'b0;
            end
        end
    end

    for (genvar c = 0; c < SYS_COL; c++) begin : g_lane
        psum_accum_lane #(
            .PSUM_WIDTH (PSUM_WIDTH),
            .ACCUM_SIZE (ACCUM_SIZE)
        ) u_lane (
            .clk          (clk),
            .rstn         (rstn),
            .wr_en        (beat_ok),
            .wr_overwrite (pass_cnt == '0),
            .wr_addr      (psum_addr),
            .wr_data      (psum_data[c]),
            .rd_en        (drain_load),
            .rd_addr      (drain_ptr),
            .rd_data      (out_data[c])
        );
    end

endmodule

// File: tb/tb_psum_accum_buf.sv
// Directed self-checking bench for psum_accum_buf: one task per scenario with
// hand-computed expected rows.
module tb_psum_accum_buf;

    import neurex_pkg::*;

    localparam int NCOL     = 4;
    localparam int ROWS_MAX = 32;

    logic              clk = 1'b0;
    logic              rstn;
    logic              start;
    logic [15:0]       num_rows;
    logic [15:0]       num_pass;
    logic              psum_valid;
    logic [4:0]        psum_addr;
    logic [0:3][31:0]  psum_data;
    logic              out_valid;
    logic              out_ready;
    logic [4:0]        out_addr;
    logic [0:3][31:0]  out_data;
    logic              busy;
    logic              done;
    logic              err;

    int    checks = 0;
    int    errors = 0;
    psum_t cap_data [ROWS_MAX][NCOL];
    logic [4:0] cap_addr [ROWS_MAX];
    int    cap_n;
    int    done_cnt;
    int    stall_seen;
    int    stall_bad;
    bit    drain_to;

    psum_accum_buf dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .num_rows   (num_rows),
        .num_pass   (num_pass),
        .psum_valid (psum_valid),
        .psum_addr  (psum_addr),
        .psum_data  (psum_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic do_start(input int rows, input int passes);
        @(negedge clk);
        start    = 1'b1;
        num_rows = 16'(rows);
        num_pass = 16'(passes);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Lane l carries d + l*step.
    task automatic send_beat(input int a, input logic [31:0] d, input logic [31:0] step);
        @(negedge clk);
        psum_valid = 1'b1;
        psum_addr  = 5'(a);
        for (int l = 0; l < NCOL; l++) psum_data[l] = d + 32'(l) * step;
    endtask

    // Collects accepted drain beats; bp selects the ready pattern 1,0,0,1.
    task automatic run_drain(input int rows, input bit bp);
        logic             r;
        int               extra;
        logic             held_v;
        logic [4:0]       held_a;
        logic [0:3][31:0] held_d;
        cap_n = 0; done_cnt = 0; stall_seen = 0; stall_bad = 0;
        drain_to = 1'b1; extra = 0; held_v = 1'b0; held_a = '0; held_d = '0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            psum_valid = 1'b0;
            if (done) done_cnt++;
            if (held_v) begin
                stall_seen++;
                if (!out_valid || out_addr !== held_a || out_data !== held_d) stall_bad++;
            end
            if (cap_n >= rows && done_cnt > 0) begin
                extra++;
                if (extra == 3) begin
                    drain_to = 1'b0;
                    break;
                end
            end
            r = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            out_ready = r;
            held_v = out_valid && !r;
            held_a = out_addr;
            held_d = out_data;
            if (out_valid && r && cap_n < ROWS_MAX) begin
                cap_addr[cap_n] = out_addr;
                for (int l = 0; l < NCOL; l++) cap_data[cap_n][l] = out_data[l];
                cap_n++;
            end
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b0; num_rows = '0; num_pass = '0;
        psum_valid = 1'b0; psum_addr = '0; psum_data = '0; out_ready = 1'b1;
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
        checks++; if (out_addr !== 5'd0) begin errors++; $display("[TB] FAIL reset_out_addr: got %0d expected 0", out_addr); end
        checks++; if (out_data !== '0) begin errors++; $display("[TB] FAIL reset_out_data: got %0h expected 0", out_data); end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] exp;
        do_start(2, 2);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy_start: got %b expected 1", busy); end
        send_beat(0, 32'd1, 32'd0);
        send_beat(1, 32'd1, 32'd0);
        send_beat(0, 32'd2, 32'd1);
        send_beat(1, 32'd2, 32'd1);
        run_drain(2, 1'b0);
        checks++; if (drain_to) begin errors++; $display("[TB] FAIL basic_timeout: got timeout expected done"); end
        checks++; if (cap_n !== 2) begin errors++; $display("[TB] FAIL basic_rows: got %0d expected 2", cap_n); end
        for (int r = 0; r < 2 && r < cap_n; r++) begin
            checks++; if (cap_addr[r] !== 5'(r)) begin errors++; $display("[TB] FAIL basic_addr: got %0d expected %0d", cap_addr[r], r); end
            for (int l = 0; l < NCOL; l++) begin
                exp = 32'd3 + 32'(l);
                checks++; if (cap_data[r][l] !== exp) begin errors++; $display("[TB] FAIL basic_data r%0d l%0d: got %0h expected %0h", r, l, cap_data[r][l], exp); end
            end
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("[TB] FAIL basic_done_pulses: got %0d expected 1", done_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_end: got %b expected 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL basic_err: got %b expected 0", err); end
    endtask

    task automatic test_back_to_back();
        do_start(1, 3);
        send_beat(0, 32'd5, 32'd0);
        send_beat(0, 32'd6, 32'd0);
        send_beat(0, 32'd7, 32'd0);
        run_drain(1, 1'b0);
        checks++; if (drain_to || cap_n !== 1) begin errors++; $display("[TB] FAIL b2b_rows: got %0d expected 1", cap_n); end
        for (int l = 0; l < NCOL; l++) begin
            checks++; if (cap_data[0][l] !== 32'd18) begin errors++; $display("[TB] FAIL b2b_data l%0d: got %0h expected 12", l, cap_data[0][l]); end
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("[TB] FAIL b2b_done_pulses: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp;
        do_start(1, 2);
        send_beat(0, 32'hFFFF_FFFF, 32'd0);
        send_beat(0, 32'd2, 32'd1);
        run_drain(1, 1'b0);
        checks++; if (drain_to || cap_n !== 1) begin errors++; $display("[TB] FAIL wrap_rows: got %0d expected 1", cap_n); end
        for (int l = 0; l < NCOL; l++) begin
            exp = 32'd1 + 32'(l);
            checks++; if (cap_data[0][l] !== exp) begin errors++; $display("[TB] FAIL wrap_data l%0d: got %0h expected %0h", l, cap_data[0][l], exp); end
        end
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL wrap_err: got %b expected 0", err); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp;
        do_start(4, 1);
        for (int r = 0; r < 4; r++) send_beat(r, 32'(100 * r), 32'd3);
        run_drain(4, 1'b1);
        checks++; if (drain_to || cap_n !== 4) begin errors++; $display("[TB] FAIL bp_rows: got %0d expected 4", cap_n); end
        for (int r = 0; r < 4 && r < cap_n; r++) begin
            checks++; if (cap_addr[r] !== 5'(r)) begin errors++; $display("[TB] FAIL bp_addr: got %0d expected %0d", cap_addr[r], r); end
            for (int l = 0; l < NCOL; l++) begin
                exp = 32'(100 * r + 3 * l);
                checks++; if (cap_data[r][l] !== exp) begin errors++; $display("[TB] FAIL bp_data r%0d l%0d: got %0h expected %0h", r, l, cap_data[r][l], exp); end
            end
        end
        checks++; if (stall_seen == 0 || stall_bad !== 0) begin errors++; $display("[TB] FAIL bp_stall_stable: got %0d unstable of %0d stalls expected 0 of >0", stall_bad, stall_seen); end
        checks++; if (done_cnt !== 1) begin errors++; $display("[TB] FAIL bp_done_pulses: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_err_config();
        do_start(3, 0);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL cfg_pass0_busy: got %b expected 0", busy); end
        checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL cfg_pass0_err: got %b expected 1", err); end
        do_start(1, 1);
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL cfg_clear_err: got %b expected 0", err); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL cfg_valid_busy: got %b expected 1", busy); end
        send_beat(0, 32'd42, 32'd0);
        run_drain(1, 1'b0);
        checks++; if (drain_to || cap_n !== 1 || cap_data[0][3] !== 32'd42) begin errors++; $display("[TB] FAIL cfg_job_data: got %0h expected 2a", cap_data[0][3]); end
        do_start(33, 1);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL cfg_rows33_busy: got %b expected 0", busy); end
        checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL cfg_rows33_err: got %b expected 1", err); end
    endtask

    task automatic test_err_addr();
        logic [31:0] exp;
        do_start(4, 1);
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL addr_err_cleared: got %b expected 0", err); end
        send_beat(0, 32'd1, 32'd1);
        send_beat(1, 32'd11, 32'd1);
        send_beat(5, 32'd99, 32'd1);
        send_beat(2, 32'd21, 32'd1);
        send_beat(3, 32'd31, 32'd1);
        run_drain(4, 1'b0);
        checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL addr_err: got %b expected 1", err); end
        checks++; if (drain_to || cap_n !== 4) begin errors++; $display("[TB] FAIL addr_rows: got %0d expected 4", cap_n); end
        for (int r = 0; r < 4 && r < cap_n; r++) begin
            for (int l = 0; l < NCOL; l++) begin
                exp = 32'(10 * r + 1 + l);
                checks++; if (cap_data[r][l] !== exp) begin errors++; $display("[TB] FAIL addr_data r%0d l%0d: got %0h expected %0h", r, l, cap_data[r][l], exp); end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp;
        do_start(2, 2);
        send_beat(0, 32'd100, 32'd0);
        @(negedge clk);
        psum_valid = 1'b0;
        rstn = 1'b0;
        #2;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_busy: got %b expected 0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_out_valid: got %b expected 0", out_valid); end
        @(negedge clk);
        rstn = 1'b1;
        send_beat(0, 32'd3, 32'd0);
        @(negedge clk);
        psum_valid = 1'b0;
        checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL idle_beat_err: got %b expected 1", err); end
        do_start(2, 2);
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_restart_err: got %b expected 0", err); end
        send_beat(0, 32'd7, 32'd0);
        send_beat(1, 32'd8, 32'd0);
        send_beat(0, 32'd1, 32'd1);
        send_beat(1, 32'd1, 32'd1);
        run_drain(2, 1'b0);
        checks++; if (drain_to || cap_n !== 2) begin errors++; $display("[TB] FAIL rst_mid_rows: got %0d expected 2", cap_n); end
        for (int r = 0; r < 2 && r < cap_n; r++) begin
            for (int l = 0; l < NCOL; l++) begin
                exp = 32'(8 + r + l);
                checks++; if (cap_data[r][l] !== exp) begin errors++; $display("[TB] FAIL rst_mid_data r%0d l%0d: got %0h expected %0h", r, l, cap_data[r][l], exp); end
            end
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("[TB] FAIL rst_mid_done_pulses: got %0d expected 1", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_wrap();
        test_backpressure();
        test_err_config();
        test_err_addr();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
